// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the tinyriscv bus fabric: pipeline hold encodings,
// RIB master indices and the RIB arbiter state type.
package tinyriscv_pkg;

  // Pipeline hold request levels
  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  // RIB master indices
  localparam logic [1:0] RIB_M0 = 2'd0;  // core load/store
  localparam logic [1:0] RIB_M1 = 2'd1;  // instruction fetch
  localparam logic [1:0] RIB_M2 = 2'd2;  // host/debug
  localparam logic [1:0] RIB_M3 = 2'd3;  // JTAG

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } rib_arb_state_e;

endpackage

// File: rtl/rib_prio_sel.sv
// Combinational fixed-priority picker for the RIB masters.
// Base order m3 > m0 > m2 > m1; a boost lets a requesting m1 win outright.
// Index defaults to m1 when nothing is requested so the mux idles on fetch.
module rib_prio_sel
  import tinyriscv_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   boost,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [1:0]             idx,
  output logic                   valid
);

  // Pick the winner among the current requesters
  always_comb begin
    gnt   = '0;
    idx   = RIB_M1;
    valid = |req;
    if (boost && req[RIB_M1]) begin
      gnt[RIB_M1] = 1'b1;
      idx         = RIB_M1;
    end else if (req[RIB_M3]) begin
      gnt[RIB_M3] = 1'b1;
      idx         = RIB_M3;
    end else if (req[RIB_M0]) begin
      gnt[RIB_M0] = 1'b1;
      idx         = RIB_M0;
    end else if (req[RIB_M2]) begin
      gnt[RIB_M2] = 1'b1;
      idx         = RIB_M2;
    end else if (req[RIB_M1]) begin
      gnt[RIB_M1] = 1'b1;
      idx         = RIB_M1;
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Registered RIB arbiter. A grant is locked until the addressed slave
// returns ready (completion), the owner drops its request (release), or the
// wait bound expires (abort with a one-cycle error pulse). Instruction fetch
// (m1) gets a boost after a run of completed transactions by other masters
// while it was waiting.
module rib_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_MAX     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   ready_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [1:0]             gnt_idx_o,
  output logic                   bus_busy_o,
  output logic                   hold_flag_o,
  output logic                   timeout_err_o,
  output logic [1:0]             err_idx_o
);

  localparam int WAIT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  // Every master except instruction fetch stalls the core pipeline
  localparam logic [NUM_MASTERS-1:0] HOLD_MASK = ~(NUM_MASTERS'(1) << RIB_M1);

  rib_arb_state_e         state_reg, state_next;
  logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
  logic [1:0]             gnt_idx_reg, gnt_idx_next;
  logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [STARVE_W-1:0]    starve_cnt_reg, starve_cnt_next;
  logic                   timeout_err_reg, timeout_err_next;
  logic [1:0]             err_idx_reg, err_idx_next;

  logic                   owner_req;
  logic                   complete;
  logic [STARVE_W-1:0]    starve_upd;
  logic                   boost;
  logic [NUM_MASTERS-1:0] sel_gnt;
  logic [1:0]             sel_idx;
  logic                   sel_valid;

  // Completion detection and starvation counter update. Re-arbitration on a
  // completion sees the updated count, so m1 wins right on the completion
  // that brings the count to STARVE_MAX.
  always_comb begin
    owner_req  = |(req_i & gnt_reg);
    complete   = (state_reg == ARB_OWNED) && ready_i && owner_req;
    starve_upd = starve_cnt_reg;
    if (complete) begin
      if ((gnt_idx_reg != RIB_M1) && req_i[RIB_M1]) begin
        if (starve_cnt_reg != STARVE_TOP) begin
          starve_upd = starve_cnt_reg + STARVE_W'(1);
        end
      end else begin
        starve_upd = '0;
      end
    end
    boost = (starve_upd == STARVE_TOP) && req_i[RIB_M1];
  end

  rib_prio_sel #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_prio_sel (
    .req   (req_i),
    .boost (boost),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // Next-state logic: grant load, completion/re-arbitration, release, timeout
  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    gnt_idx_next     = gnt_idx_reg;
    wait_cnt_next    = wait_cnt_reg;
    starve_cnt_next  = starve_upd;
    timeout_err_next = 1'b0;
    err_idx_next     = err_idx_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (sel_valid) begin
          state_next    = ARB_OWNED;
          gnt_next      = sel_gnt;
          gnt_idx_next  = sel_idx;
          wait_cnt_next = '0;
        end
      end
      ARB_OWNED: begin
        if (complete) begin
          wait_cnt_next = '0;
          if (sel_valid) begin
            gnt_next     = sel_gnt;
            gnt_idx_next = sel_idx;
          end else begin
            state_next   = ARB_IDLE;
            gnt_next     = '0;
            gnt_idx_next = RIB_M1;
          end
        end else if (!owner_req) begin
          state_next    = ARB_IDLE;
          gnt_next      = '0;
          gnt_idx_next  = RIB_M1;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next       = ARB_IDLE;
          gnt_next         = '0;
          gnt_idx_next     = RIB_M1;
          wait_cnt_next    = '0;
          timeout_err_next = 1'b1;
          err_idx_next     = gnt_idx_reg;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: begin
        state_next    = ARB_IDLE;
        gnt_next      = '0;
        gnt_idx_next  = RIB_M1;
        wait_cnt_next = '0;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ARB_IDLE;
      gnt_reg         <= '0;
      gnt_idx_reg     <= RIB_M1;
      wait_cnt_reg    <= '0;
      starve_cnt_reg  <= '0;
      timeout_err_reg <= 1'b0;
      err_idx_reg     <= RIB_M0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      gnt_idx_reg     <= gnt_idx_next;
      wait_cnt_reg    <= wait_cnt_next;
      starve_cnt_reg  <= starve_cnt_next;
      timeout_err_reg <= timeout_err_next;
      err_idx_reg     <= err_idx_next;
    end
  end

  // Outputs; hold is combinational so the core stalls before the grant lands
  always_comb begin
    gnt_o         = gnt_reg;
    gnt_idx_o     = gnt_idx_reg;
    bus_busy_o    = (state_reg == ARB_OWNED);
    timeout_err_o = timeout_err_reg;
    err_idx_o     = err_idx_reg;
    hold_flag_o   = (|((req_i | gnt_reg) & HOLD_MASK)) ? HoldEnable : HoldDisable;
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed testbench for rib_arbiter: reset, hold flag, priority, lock,
// timeout, completion-vs-timeout, starvation boost and async reset.
module tb_rib_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       hold;
  logic       terr;
  logic [1:0] eidx;

  int n_checks = 0;
  int n_pass   = 0;

  rib_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16),
    .STARVE_MAX     (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .ready_i       (ready),
    .gnt_o         (gnt),
    .gnt_idx_o     (gnt_idx),
    .bus_busy_o    (busy),
    .hold_flag_o   (hold),
    .timeout_err_o (terr),
    .err_idx_o     (eidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %0h expected %0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full grant view in one call
  task automatic check_gnt(input string tag, input logic [3:0] exp_gnt,
                           input logic [1:0] exp_idx, input logic exp_busy);
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;

    // Reset values
    tick();
    tick();
    check_gnt("rst", 4'b0000, 2'd1, 1'b0);
    check("rst_hold", 32'(hold), 32'(0));
    check("rst_terr", 32'(terr), 32'(0));
    check("rst_eidx", 32'(eidx), 32'(0));
    req = 4'b1111;
    tick();
    check_gnt("rst_req", 4'b0000, 2'd1, 1'b0);
    check("rst_req_hold", 32'(hold), 32'(1));

    // Release reset: m3 wins on the first edge
    rst_n = 1'b1;
    tick();
    check_gnt("rel", 4'b1000, 2'd3, 1'b1);

    // Owner drops request without ready: release to idle
    req = 4'b0000;
    tick();
    check_gnt("drop", 4'b0000, 2'd1, 1'b0);
    check("drop_terr", 32'(terr), 32'(0));
    check("idle_hold", 32'(hold), 32'(0));

    // Hold flag is combinational and ignores m1
    req = 4'b0010;
    #1;
    check("hold_m1", 32'(hold), 32'(0));
    req = 4'b0001;
    #1;
    check("hold_m0", 32'(hold), 32'(1));
    check("hold_m0_gnt", 32'(gnt), 32'(0));

    // Priority with m0, m1, m2 requesting: m0 wins repeatedly
    req   = 4'b0111;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_gnt($sformatf("prio_m0_%0d", i), 4'b0001, 2'd0, 1'b1);
    end
    req = 4'b0110;
    tick();
    check_gnt("prio_rel0", 4'b0000, 2'd1, 1'b0);
    tick();
    check_gnt("prio_m2a", 4'b0100, 2'd2, 1'b1);
    tick();
    check_gnt("prio_m2b", 4'b0100, 2'd2, 1'b1);
    req = 4'b0010;
    tick();
    check_gnt("prio_rel2", 4'b0000, 2'd1, 1'b0);
    tick();
    check_gnt("prio_m1a", 4'b0010, 2'd1, 1'b1);
    check("prio_m1_hold", 32'(hold), 32'(0));
    tick();
    check_gnt("prio_m1b", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    check_gnt("prio_end", 4'b0000, 2'd1, 1'b0);

    // Lock: m0 holds the bus while m3 waits for ready
    req   = 4'b0001;
    ready = 1'b0;
    tick();
    check_gnt("lock_m0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_gnt($sformatf("lock_hold_%0d", i), 4'b0001, 2'd0, 1'b1);
    end
    ready = 1'b1;
    tick();
    check_gnt("lock_m3", 4'b1000, 2'd3, 1'b1);
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    check_gnt("lock_end", 4'b0000, 2'd1, 1'b0);

    // Timeout: m2 waits 16 cycles without ready
    req = 4'b0100;
    tick();
    check_gnt("to_m2", 4'b0100, 2'd2, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("to_wait_%0d_gnt", i), 32'(gnt), 32'(4'b0100));
      check($sformatf("to_wait_%0d_terr", i), 32'(terr), 32'(0));
    end
    tick();
    check_gnt("to_abort", 4'b0000, 2'd1, 1'b0);
    check("to_terr", 32'(terr), 32'(1));
    check("to_eidx", 32'(eidx), 32'(2));
    tick();
    check("to_pulse_end", 32'(terr), 32'(0));
    check_gnt("to_regrant", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    check_gnt("to_end", 4'b0000, 2'd1, 1'b0);

    // Completion on the threshold cycle wins over timeout
    req = 4'b0100;
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
    end
    ready = 1'b1;
    tick();
    check("tie_terr", 32'(terr), 32'(0));
    check_gnt("tie_gnt", 4'b0100, 2'd2, 1'b1);
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    check_gnt("tie_end", 4'b0000, 2'd1, 1'b0);

    // Starvation: m1 boosted after exactly 8 m0 completions, then counter restarts
    req   = 4'b0011;
    ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 8 || i == 17) begin
        check($sformatf("starve_%0d", i), 32'(gnt), 32'(4'b0010));
      end else begin
        check($sformatf("starve_%0d", i), 32'(gnt), 32'(4'b0001));
      end
    end
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    check_gnt("starve_end", 4'b0000, 2'd1, 1'b0);

    // Asynchronous reset while owned with wait_cnt at 10
    req = 4'b0100;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    check("ar_pre_gnt", 32'(gnt), 32'(4'b0100));
    #1;
    rst_n = 1'b0;
    #1;
    check_gnt("ar_now", 4'b0000, 2'd1, 1'b0);
    check("ar_now_terr", 32'(terr), 32'(0));
    tick();
    tick();
    check("ar_later_terr", 32'(terr), 32'(0));
    check("ar_later_eidx", 32'(eidx), 32'(0));
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    check_gnt("ar_rel", 4'b0000, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
